// File: rtl/inbound_fsm.sv
// inbound_fsm - register-slave front end for the PCIe inbound (host-to-device) path.
//
// This block holds the host-visible command registers (CMD, LEN, ADDR0, ADDR1).
// A host read that needs a completion becomes a completion-with-data entry.
// A write of CMD becomes one write-DMA command per started slot.
// Both kinds of entry are pushed into the upstream command FIFO.
//
// Ports:
//   clk                      sole clock, rising edge
//   rst_n                    asynchronous reset, ACTIVE HIGH (legacy name)
//   up_wr_cmd_compl_i        pulse: write command cmd_id_i[0] has finished
//   cmd_id_i[1:0]            completed slot (bit 1 ignored)
//   req_compl_i              pulse: host read needs a completion
//   req_compl_with_data_i    completion carries data
//   to_rxe_compl_done_o      pulse when the completion entry is pushed
//   rd_addr_i/rd_be_i        register read address / byte enables
//   rd_data_o                registered read data
//   wr_addr_i/wr_be_i/wr_data_i/wr_en_i   register write port (wr_be_i[3:0] used)
//   wr_busy_o                a write is being processed; next write must wait
//   req_*_i                  request header fields
//   us_cmd_fifo_full_i       FIFO full, no pushes
//   us_cmd_fifo_prog_full_i  FIFO almost full, no new write commands
//   us_cmd_fifo_din_o        FIFO entry
//   us_cmd_fifo_wr_en_o      FIFO push strobe
//
// Build option: define INBOUND_RD_BE_MASK_EN to return 0x00 in rd_data_o bytes
// whose rd_be_i bit is 0. Without it, rd_be_i is ignored.
//
// FSM states:
//   state | meaning
//   IDLE  | nothing waiting
//   CPLD  | completion latched, waiting for FIFO space
//   WCMD  | started slots still to be pushed as write commands
module inbound_fsm (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_wr_cmd_compl_i,
  input  logic [1:0]    cmd_id_i,
  input  logic          req_compl_i,
  input  logic          req_compl_with_data_i,
  output logic          to_rxe_compl_done_o,
  input  logic [10:0]   rd_addr_i,
  input  logic [3:0]    rd_be_i,
  output logic [31:0]   rd_data_o,
  input  logic [10:0]   wr_addr_i,
  input  logic [7:0]    wr_be_i,
  input  logic [31:0]   wr_data_i,
  input  logic          wr_en_i,
  output logic          wr_busy_o,
  input  logic [2:0]    req_tc_i,
  input  logic          req_td_i,
  input  logic          req_ep_i,
  input  logic [1:0]    req_attr_i,
  input  logic [9:0]    req_len_i,
  input  logic [15:0]   req_rid_i,
  input  logic [7:0]    req_tag_i,
  input  logic [7:0]    req_be_i,
  input  logic [12:0]   req_addr_i,
  input  logic          us_cmd_fifo_full_i,
  input  logic          us_cmd_fifo_prog_full_i,
  output logic [127:0]  us_cmd_fifo_din_o,
  output logic          us_cmd_fifo_wr_en_o
);

  localparam logic [1:0] US_CMD_WR32_TYPE = 2'b01;
  localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPLD = 2'd1,
    WCMD = 2'd2
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [1:0]   state;        // pending bitmap, one bit per slot
  logic [54:0]  req_d;        // latched request header (register despite the name)
  logic         cpl_wd_q;
  logic [31:0]  cpl_data_q;
  logic [1:0]   start_q, start_d;
  logic [4:0]   len_q;
  logic [31:2]  addr0_q, addr1_q;

  logic         wr_accept, cmd_wr, cpl_cur, cpl_hold, wslot;
  logic         push_cpl, push_wcmd, busy_d, cpl_wd;
  logic [1:0]   start_cur, state_d, set_mask, clr_mask;
  logic [54:0]  req_now, cpl_req;
  logic [31:0]  cpl_data, req_rdval, rd_val, addr0_wr, addr1_wr, wcmd_addr;
  logic [127:0] din_d;
  logic         unused_ok;

  function automatic logic [31:0] reg_read(input logic [10:0] a, input logic [1:0] st,
                                           input logic [4:0] ln, input logic [31:2] a0,
                                           input logic [31:2] a1);
    logic [31:0] v;
    v = '0;
    case (a)
      11'd0:   v = {30'd0, st};
      11'd1:   v = {27'd0, ln};
      11'd4:   v = {a0, 2'b00};
      11'd6:   v = {a1, 2'b00};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) begin
      v[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    end
    return v;
  endfunction

  assign unused_ok = ^{wr_be_i[7:4], cmd_id_i[1], rd_be_i, addr0_wr[1:0], addr1_wr[1:0]};

  always_comb begin
    wr_accept = wr_en_i & ~wr_busy_o;
    cmd_wr    = wr_accept & (wr_addr_i == 11'd0) & wr_be_i[0];
    // Slots already pending are masked out of a new start bitmap.
    start_cur = start_q | (cmd_wr ? (wr_data_i[1:0] & ~state) : 2'b00);

    addr0_wr = be_merge({addr0_q, 2'b00}, wr_data_i, wr_be_i[3:0]);
    addr1_wr = be_merge({addr1_q, 2'b00}, wr_data_i, wr_be_i[3:0]);

    req_now   = {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i,
                 req_rid_i, req_tag_i, req_be_i, req_addr_i[5:0]};
    req_rdval = reg_read(req_addr_i[12:2], state, len_q, addr0_q, addr1_q);

    // A held completion wins over a new request; the new one is dropped.
    cpl_cur  = (fsm_q == CPLD) | req_compl_i;
    cpl_req  = (fsm_q == CPLD) ? req_d      : req_now;
    cpl_wd   = (fsm_q == CPLD) ? cpl_wd_q   : req_compl_with_data_i;
    cpl_data = (fsm_q == CPLD) ? cpl_data_q : req_rdval;

    wslot     = ~start_cur[0];
    wcmd_addr = wslot ? {addr1_q, 2'b00} : {addr0_q, 2'b00};

    push_cpl  = 1'b0;
    push_wcmd = 1'b0;
    cpl_hold  = 1'b0;
    start_d   = start_cur;
    // Completions take priority over write commands.
    if (cpl_cur) begin
      if (!us_cmd_fifo_full_i) push_cpl = 1'b1;
      else                     cpl_hold = 1'b1;
    end else if ((start_cur != 2'b00) && !us_cmd_fifo_full_i && !us_cmd_fifo_prog_full_i) begin
      push_wcmd = 1'b1;
      start_d   = wslot ? (start_cur & 2'b01) : (start_cur & 2'b10);
    end

    if (cpl_hold)                fsm_d = CPLD;
    else if (start_d != 2'b00)   fsm_d = WCMD;
    else                         fsm_d = IDLE;

    set_mask = push_wcmd ? (wslot ? 2'b10 : 2'b01) : 2'b00;
    clr_mask = up_wr_cmd_compl_i ? (cmd_id_i[0] ? 2'b10 : 2'b01) : 2'b00;
    state_d  = (state & ~clr_mask) | set_mask;

    busy_d = wr_accept | push_wcmd | (start_d != 2'b00);

    din_d = '0;
    if (push_cpl) begin
      din_d = {32'd0, cpl_data, US_CMD_CPLD_TYPE, cpl_wd, 6'd0, cpl_req};
    end else if (push_wcmd) begin
      din_d = {64'd0, US_CMD_WR32_TYPE, len_q, 1'b0, wslot, 23'd0, wcmd_addr};
    end

    rd_val = reg_read(rd_addr_i, state, len_q, addr0_q, addr1_q);
`ifdef INBOUND_RD_BE_MASK_EN
    for (int b = 0; b < 4; b++) begin
      if (!rd_be_i[b]) rd_val[8*b +: 8] = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fsm_q               <= IDLE;
      state               <= '0;
      req_d               <= '0;
      cpl_wd_q            <= 1'b0;
      cpl_data_q          <= '0;
      start_q             <= '0;
      len_q               <= '0;
      addr0_q             <= '0;
      addr1_q             <= '0;
      rd_data_o           <= '0;
      wr_busy_o           <= 1'b0;
      us_cmd_fifo_din_o   <= '0;
      us_cmd_fifo_wr_en_o <= 1'b0;
      to_rxe_compl_done_o <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state   <= state_d;
      start_q <= start_d;
      if (req_compl_i && (fsm_q != CPLD)) begin
        req_d      <= req_now;
        cpl_wd_q   <= req_compl_with_data_i;
        cpl_data_q <= req_rdval;
      end
      if (wr_accept) begin
        case (wr_addr_i)
          11'd1:   if (wr_be_i[0]) len_q <= wr_data_i[4:0];
          11'd4:   addr0_q <= addr0_wr[31:2];
          11'd6:   addr1_q <= addr1_wr[31:2];
          default: ;
        endcase
      end
      rd_data_o           <= rd_val;
      wr_busy_o           <= busy_d;
      us_cmd_fifo_din_o   <= din_d;
      us_cmd_fifo_wr_en_o <= push_cpl | push_wcmd;
      to_rxe_compl_done_o <= push_cpl;
    end
  end

endmodule

// File: tb/tb_inbound_fsm.sv
module tb_inbound_fsm;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_wr_cmd_compl_i;
  logic [1:0]   cmd_id_i;
  logic         req_compl_i;
  logic         req_compl_with_data_i;
  logic         to_rxe_compl_done_o;
  logic [10:0]  rd_addr_i;
  logic [3:0]   rd_be_i;
  logic [31:0]  rd_data_o;
  logic [10:0]  wr_addr_i;
  logic [7:0]   wr_be_i;
  logic [31:0]  wr_data_i;
  logic         wr_en_i;
  logic         wr_busy_o;
  logic [2:0]   req_tc_i;
  logic         req_td_i;
  logic         req_ep_i;
  logic [1:0]   req_attr_i;
  logic [9:0]   req_len_i;
  logic [15:0]  req_rid_i;
  logic [7:0]   req_tag_i;
  logic [7:0]   req_be_i;
  logic [12:0]  req_addr_i;
  logic         us_cmd_fifo_full_i;
  logic         us_cmd_fifo_prog_full_i;
  logic [127:0] us_cmd_fifo_din_o;
  logic         us_cmd_fifo_wr_en_o;

  inbound_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .up_wr_cmd_compl_i(up_wr_cmd_compl_i), .cmd_id_i(cmd_id_i),
    .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
    .to_rxe_compl_done_o(to_rxe_compl_done_o),
    .rd_addr_i(rd_addr_i), .rd_be_i(rd_be_i), .rd_data_o(rd_data_o),
    .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .wr_en_i(wr_en_i), .wr_busy_o(wr_busy_o),
    .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
    .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
    .req_tag_i(req_tag_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i),
    .us_cmd_fifo_full_i(us_cmd_fifo_full_i),
    .us_cmd_fifo_prog_full_i(us_cmd_fifo_prog_full_i),
    .us_cmd_fifo_din_o(us_cmd_fifo_din_o), .us_cmd_fifo_wr_en_o(us_cmd_fifo_wr_en_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [127:0] sb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] wcmd_e(input logic id, input logic [4:0] ln, input logic [31:0] a);
    return {64'd0, 2'b01, ln, 1'b0, id, 23'd0, a};
  endfunction

  function automatic logic [127:0] cpl_e(input logic wd, input logic [54:0] rq, input logic [31:0] d);
    return {32'd0, d, 2'b00, wd, 6'd0, rq};
  endfunction

  function automatic logic [54:0] mk_req(input logic [2:0] tc, input logic td, input logic ep,
                                         input logic [1:0] attr, input logic [9:0] ln,
                                         input logic [15:0] rid, input logic [7:0] tag,
                                         input logic [7:0] be, input logic [12:0] a);
    return {tc, td, ep, attr, ln, rid, tag, be, a[5:0]};
  endfunction

  // Scoreboard consumer: every push must match the oldest expected entry.
  always @(negedge clk) begin
    logic [127:0] e;
    if (us_cmd_fifo_wr_en_o) begin
      if (sb.size() == 0) chk("unexpected_push", 1'b1, 1'b0);
      else begin
        e = sb.pop_front();
        chk("fifo_din", us_cmd_fifo_din_o, e);
        chk("done_with_cpl", to_rxe_compl_done_o, (e[63:62] == 2'b00));
      end
    end else if (to_rxe_compl_done_o) begin
      chk("done_without_push", 1'b1, 1'b0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_wr(input logic [10:0] a, input logic [31:0] d, input logic [7:0] be);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_be_i = be;
    step(1);
    wr_en_i = 1'b0;
  endtask

  task automatic plain_wr(input logic [10:0] a, input logic [31:0] d, input logic [7:0] be);
    do_wr(a, d, be);
    chk("busy_after_wr", wr_busy_o, 1'b1);
    step(1);
    chk("busy_one_cycle", wr_busy_o, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [10:0] a, input logic [31:0] exp);
    rd_addr_i = a;
    step(1);
    chk(tag, rd_data_o, exp);
  endtask

  task automatic wr_done(input logic [1:0] id);
    up_wr_cmd_compl_i = 1'b1; cmd_id_i = id;
    step(1);
    up_wr_cmd_compl_i = 1'b0;
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 20 && wr_busy_o; i++) step(1);
    chk("busy_release", wr_busy_o, 1'b0);
  endtask

  task automatic send_cpl(input logic wd, input logic [54:0] rq_exp, input logic [31:0] d_exp,
                          input logic [2:0] tc, input logic td, input logic ep,
                          input logic [1:0] attr, input logic [9:0] ln, input logic [15:0] rid,
                          input logic [7:0] tag, input logic [7:0] be, input logic [12:0] a,
                          input bit expect_push);
    req_tc_i = tc; req_td_i = td; req_ep_i = ep; req_attr_i = attr; req_len_i = ln;
    req_rid_i = rid; req_tag_i = tag; req_be_i = be; req_addr_i = a;
    req_compl_with_data_i = wd; req_compl_i = 1'b1;
    if (expect_push) sb.push_back(cpl_e(wd, rq_exp, d_exp));
    step(1);
    req_compl_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [54:0] rq1, rq2, rq3;
    rst_n = 1'b1;
    up_wr_cmd_compl_i = 0; cmd_id_i = 0; req_compl_i = 0; req_compl_with_data_i = 0;
    rd_addr_i = 0; rd_be_i = 4'hF; wr_addr_i = 0; wr_be_i = 0; wr_data_i = 0; wr_en_i = 0;
    req_tc_i = 0; req_td_i = 0; req_ep_i = 0; req_attr_i = 0; req_len_i = 0; req_rid_i = 0;
    req_tag_i = 0; req_be_i = 0; req_addr_i = 0;
    us_cmd_fifo_full_i = 0; us_cmd_fifo_prog_full_i = 0;
    step(3);
    chk("rst_wr_en", us_cmd_fifo_wr_en_o, 1'b0);
    chk("rst_din", us_cmd_fifo_din_o, 128'd0);
    chk("rst_done", to_rxe_compl_done_o, 1'b0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_busy", wr_busy_o, 1'b0);
    chk("rst_state", dut.state, 2'b00);
    chk("rst_req_d", dut.req_d, 55'd0);
    rst_n = 1'b0;
    step(1);

    // Register write / read-back
    plain_wr(11'd4, 32'h12345678, 8'hFF);
    rd_chk("rd_addr0", 11'd4, 32'h12345678);

    // Completion with data from ADDR0 (req_addr 0x10 -> dword 4)
    rq1 = mk_req(3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'd0, 8'h05, 8'h0F, 13'h10);
    send_cpl(1'b1, rq1, 32'h12345678, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'd0, 8'h05, 8'h0F, 13'h10, 1'b1);
    chk("cpl_push_n1", us_cmd_fifo_wr_en_o, 1'b1);
    chk("cpl_done_n1", to_rxe_compl_done_o, 1'b1);
    chk("req_d_1", dut.req_d, rq1);

    // LEN / ADDR setup and a two-slot CMD write
    plain_wr(11'd1, 32'h0000_0007, 8'h0F);
    plain_wr(11'd4, 32'hAAAA5557, 8'h0F);
    plain_wr(11'd6, 32'h0BCD0100, 8'h0F);
    rd_chk("rd_addr0_low_bits", 11'd4, 32'hAAAA5554);
    rd_chk("rd_len", 11'd1, 32'd7);
    sb.push_back(wcmd_e(1'b0, 5'd7, 32'hAAAA5554));
    sb.push_back(wcmd_e(1'b1, 5'd7, 32'h0BCD0100));
    do_wr(11'd0, 32'd3, 8'h01);
    chk("wcmd0_push_n1", us_cmd_fifo_wr_en_o, 1'b1);
    chk("cmd_busy_n1", wr_busy_o, 1'b1);
    step(1);
    chk("wcmd1_push_n2", us_cmd_fifo_wr_en_o, 1'b1);
    wait_not_busy();
    chk("state_11", dut.state, 2'b11);
    rd_chk("rd_cmd_state", 11'd0, 32'd3);

    // Rewrite ADDR0 while pending, retire both slots, restart
    plain_wr(11'd4, 32'hC0DE0008, 8'hFF);
    rd_chk("rd_addr0_pending", 11'd4, 32'hC0DE0008);
    wr_done(2'b00);
    chk("state_clr0", dut.state, 2'b10);
    wr_done(2'b11);
    chk("state_clr1", dut.state, 2'b00);
    sb.push_back(wcmd_e(1'b0, 5'd7, 32'hC0DE0008));
    sb.push_back(wcmd_e(1'b1, 5'd7, 32'h0BCD0100));
    do_wr(11'd0, 32'd3, 8'h01);
    wait_not_busy();
    chk("state_11_again", dut.state, 2'b11);
    // Starting already-pending slots does nothing
    do_wr(11'd0, 32'd3, 8'h01);
    chk("no_push_pending", us_cmd_fifo_wr_en_o, 1'b0);
    wait_not_busy();
    wr_done(2'b10);
    wr_done(2'b01);
    chk("state_cleared", dut.state, 2'b00);

    // Byte enables and unmapped addresses
    plain_wr(11'd6, 32'hFFFFFFFF, 8'h02);
    rd_chk("rd_addr1_partial_be", 11'd6, 32'h0BCDFF00);
    plain_wr(11'd2, 32'hDEADBEEF, 8'hFF);
    rd_chk("rd_unmapped", 11'd2, 32'd0);

    // FIFO full holds a completion; a second request is dropped
    us_cmd_fifo_full_i = 1'b1;
    rq2 = mk_req(3'b101, 1'b1, 1'b0, 2'b10, 10'h3FF, 16'hBEEF, 8'hA5, 8'hF0, 13'h0004);
    send_cpl(1'b0, rq2, 32'd7, 3'b101, 1'b1, 1'b0, 2'b10, 10'h3FF, 16'hBEEF, 8'hA5, 8'hF0, 13'h0004, 1'b1);
    chk("full_no_push", us_cmd_fifo_wr_en_o, 1'b0);
    step(1);
    send_cpl(1'b1, 55'd0, 32'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'd1, 8'h11, 8'h0F, 13'h0, 1'b0);
    chk("full_still_no_push", us_cmd_fifo_wr_en_o, 1'b0);
    chk("req_d_kept", dut.req_d, rq2);
    us_cmd_fifo_full_i = 1'b0;
    step(1);
    chk("release_push", us_cmd_fifo_wr_en_o, 1'b1);
    chk("release_done", to_rxe_compl_done_o, 1'b1);
    step(1);
    chk("single_push", us_cmd_fifo_wr_en_o, 1'b0);

    // prog_full stalls write commands but not completions
    us_cmd_fifo_prog_full_i = 1'b1;
    do_wr(11'd0, 32'd1, 8'h01);
    chk("pfull_no_wcmd", us_cmd_fifo_wr_en_o, 1'b0);
    step(2);
    chk("pfull_busy", wr_busy_o, 1'b1);
    rq3 = mk_req(3'd0, 1'b0, 1'b1, 2'd1, 10'd2, 16'h1234, 8'h22, 8'hFF, 13'h0018);
    send_cpl(1'b1, rq3, 32'h0BCDFF00, 3'd0, 1'b0, 1'b1, 2'd1, 10'd2, 16'h1234, 8'h22, 8'hFF, 13'h0018, 1'b1);
    chk("pfull_cpl_push", us_cmd_fifo_wr_en_o, 1'b1);
    step(1);
    sb.push_back(wcmd_e(1'b0, 5'd7, 32'hC0DE0008));
    us_cmd_fifo_prog_full_i = 1'b0;
    wait_not_busy();
    chk("state_01", dut.state, 2'b01);

    // Reset in the middle of WCMD
    us_cmd_fifo_prog_full_i = 1'b1;
    do_wr(11'd0, 32'd2, 8'h01);
    step(2);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_wr_en", us_cmd_fifo_wr_en_o, 1'b0);
    chk("mid_rst_din", us_cmd_fifo_din_o, 128'd0);
    chk("mid_rst_busy", wr_busy_o, 1'b0);
    chk("mid_rst_state", dut.state, 2'b00);
    chk("mid_rst_fsm", dut.fsm_q, 2'd0);
    us_cmd_fifo_prog_full_i = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(4);
    chk("post_rst_idle", wr_busy_o, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
